// File: rtl/tl_dmi_responder.sv
// TileLink-UL responder for the DMI-to-TL bridge: a small word-addressed register
// bank (word 0 = read-only ID) behind a single-entry registered D-response buffer.
module tl_dmi_responder #(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] ID_VALUE = 32'h0000_0001
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [8:0]  auto_in_a_bits_address,
    input  logic [3:0]  auto_in_a_bits_mask,
    input  logic [31:0] auto_in_a_bits_data,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic        auto_in_d_bits_denied,
    output logic [31:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt,
    output logic        err_sticky
);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] D_ACK          = 3'd0;
    localparam logic [2:0] D_ACK_DATA     = 3'd1;
    localparam logic [7:0] DEPTH_L        = 8'(DEPTH);

    logic        d_valid_q;
    logic [2:0]  d_opcode_q, d_opcode_d;
    logic        d_denied_q, d_denied_d;
    logic [31:0] d_data_q, d_data_d;
    logic        err_q;
    logic [31:0] bank_q [DEPTH];

    logic        a_fire;
    logic [6:0]  idx;
    logic        op_legal;
    logic [31:0] rd_word;
    logic        wr_en;
    logic [3:0]  wr_mask;

    // Handshake: a channel transfers on a cycle where valid && ready are both high;
    // valid never waits on ready, and the buffer accepts a new request whenever it is
    // empty or is being drained on the same edge.
    assign auto_in_a_ready = !d_valid_q || auto_in_d_ready;
    assign a_fire          = auto_in_a_valid && auto_in_a_ready;
    assign idx             = auto_in_a_bits_address[8:2];
    assign op_legal        = (auto_in_a_bits_opcode == OP_PUT_FULL)
                          || (auto_in_a_bits_opcode == OP_PUT_PARTIAL)
                          || (auto_in_a_bits_opcode == OP_GET);

    always_comb begin
        rd_word = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (idx == 7'(i)) rd_word = bank_q[i];
        end
    end

    always_comb begin
        d_opcode_d = D_ACK;
        d_denied_d = 1'b0;
        d_data_d   = '0;
        wr_en      = 1'b0;
        wr_mask    = '0;
        if (auto_in_a_bits_opcode == OP_PUT_PARTIAL && auto_in_a_bits_mask == 4'b0000) begin
            // Bridge idle op: acknowledged at any address, never an error.
            d_opcode_d = D_ACK;
        end else if (!op_legal || auto_in_a_bits_address[1:0] != 2'b00
                     || {1'b0, idx} >= DEPTH_L) begin
            d_denied_d = 1'b1;
            d_opcode_d = (auto_in_a_bits_opcode == OP_GET) ? D_ACK_DATA : D_ACK;
        end else if (auto_in_a_bits_opcode == OP_GET) begin
            d_opcode_d = D_ACK_DATA;
            d_data_d   = (idx == 7'd0) ? ID_VALUE : rd_word;
        end else begin
            wr_en   = 1'b1;
            wr_mask = (auto_in_a_bits_opcode == OP_PUT_FULL) ? 4'hF : auto_in_a_bits_mask;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_valid_q  <= 1'b0;
            d_opcode_q <= D_ACK;
            d_denied_q <= 1'b0;
            d_data_q   <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
        end else begin
            if (a_fire) begin
                d_valid_q  <= 1'b1;
                d_opcode_q <= d_opcode_d;
                d_denied_q <= d_denied_d;
                d_data_q   <= d_data_d;
                err_q      <= err_q | d_denied_d;
            end else if (auto_in_d_ready) begin
                d_valid_q <= 1'b0;
            end
            // Word 0 is the ID register, so the write loop starts at 1.
            if (a_fire && wr_en) begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (idx == 7'(i)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wr_mask[b]) bank_q[i][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    assign auto_in_d_valid        = d_valid_q;
    assign auto_in_d_bits_opcode  = d_opcode_q;
    assign auto_in_d_bits_denied  = d_denied_q;
    assign auto_in_d_bits_data    = d_data_q;
    assign auto_in_d_bits_corrupt = 1'b0;
    assign err_sticky             = err_q;

endmodule

// File: doc/tl_dmi_responder.md
Name: tl_dmi_responder

Overview:
- TileLink-UL responder terminating the A channel produced by the DMI-to-TL bridge; returns D-channel responses that the bridge forwards as DMI responses.
- Holds a small word-addressed register bank (DMI debug registers), with word 0 a read-only ID register.
- Single-entry D-response buffer; sustains one request per cycle when the D channel drains every cycle.

Parameters:
- DEPTH, 16, number of 32-bit words in the bank; word index = address[8:2]; legal range 1..64.
- ID_VALUE, 32'h0000_0001, value returned by word 0 (read-only).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- auto_in_a_ready  output  1  A-channel ready.
- auto_in_a_valid  input  1  A-channel valid.
- auto_in_a_bits_opcode  input  3  0=PutFullData, 1=PutPartialData, 4=Get; others illegal.
- auto_in_a_bits_address  input  9  byte address.
- auto_in_a_bits_mask  input  4  byte-lane write enables.
- auto_in_a_bits_data  input  32  write data.
- auto_in_d_ready  input  1  D-channel ready.
- auto_in_d_valid  output  1  D-channel valid.
- auto_in_d_bits_opcode  output  3  0=AccessAck, 1=AccessAckData.
- auto_in_d_bits_denied  output  1  request rejected.
- auto_in_d_bits_data  output  32  read data, 0 for non-Get.
- auto_in_d_bits_corrupt  output  1  tied 0.
- err_sticky  output  1  set by any denied response; cleared only by reset.

Behaviour:
- Reset (async assert): d_valid=0, d_opcode=0, d_denied=0, d_data=0, err_sticky=0, bank words 1..DEPTH-1 = 0. a_ready is combinational and reads 1 while reset is deasserted and the buffer is empty.
- a_ready = !d_valid || d_ready. A fires on a_valid && a_ready.
- Latency: response appears on D on the cycle after A fires (1 cycle). Response fields are registered and held stable while d_valid && !d_ready.
- Buffer update per cycle:
  - A fire: load the new response and set d_valid=1. This covers simultaneous D drain and A fire, giving back-to-back responses with no bubble.
  - D fire without A fire: clear d_valid.
  - Otherwise: hold.
- Decode order on A fire, first match wins:
  - NOP: opcode=1 && mask=0. AccessAck, denied=0, regardless of address. The bridge's idle op, address 0x40, must not error.
  - Illegal: opcode not in {0,1,4}. Response opcode = AccessAckData if opcode was 4, else AccessAck; denied=1; no state change.
  - Misaligned: address[1:0]!=0. Denied=1, same opcode rule.
  - Unmapped: address[8:2] >= DEPTH. Denied=1.
  - Get: AccessAckData. Data = ID_VALUE for index 0, else bank[index].
  - PutFull: AccessAck. Writes all 4 bytes, ignoring the mask.
  - PutPartial: AccessAck. Writes byte lane i only when mask[i]=1.
  - Writes to index 0 are ignored but acked, not denied.
- Bank write takes effect at the A-fire edge. A Get to the same word in the next cycle returns the new value; no read-during-write hazard exists, since a Get fires at least one cycle after the Put.
- d_data is 0 for all AccessAck and all denied responses.
- err_sticky sets on the same edge the denied response is loaded.
- A-channel inputs are ignored when a_valid=0 or a_ready=0; no state change.
- Reset mid-transaction drops any pending D response. No response is issued after reset deasserts.

Test Plan:
- Reset, then Get addr 0x000 -> d_valid one cycle after fire, opcode=1, data=0x00000001, denied=0.
- PutFull addr 0x008 data 0xDEADBEEF, then Get 0x008 -> AccessAck then AccessAckData 0xDEADBEEF. Next, PutPartial 0x008 mask 4'b0010 data 0x00001100, then Get -> 0xDEAD11EF.
- Bridge NOP: opcode=1, mask=0, addr 0x040 -> AccessAck, denied=0, err_sticky stays 0. Then Get 0x040 (index 16, DEPTH=16) -> AccessAckData, denied=1, data=0, err_sticky=1.
- Opcode 3 at 0x004, and Get at 0x006 -> both denied=1, bank unchanged.
- Backpressure: hold d_ready=0 with a_valid=1 -> a_ready=0, D fields stable for 5 cycles. Then d_ready=1 with continuous Gets -> one response per cycle, no bubble.
- Assert reset while d_valid=1 and d_ready=0 -> d_valid=0 immediately (async). Bank reads 0 after release; word 0 still reads ID_VALUE.
